// File: rtl/seg_pattern_driver.sv
// -----------------------------------------------------------------------------
// seg_pattern_driver
//
// Stimulus source and scoreboard for a 7-input digit classifier. Each trial
// encodes the current digit as a 7-segment pattern, optionally flips one
// segment chosen by a 16-bit Galois LFSR, waits LAT cycles for the
// classifier's registered prediction, then compares the prediction against
// the clean digit and updates the match/trial counters.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start         begins a run when sampled high in IDLE
//   abort         ends the current run early (ignored in IDLE)
//   mode          0 = fixed digit, 1 = sweep starting at digit_in
//   digit_in      start/fixed digit, latched at start
//   noise_en      enables single-segment flip, latched at start
//   num_trials    trials per run, latched at start
//   pred_in       classifier prediction
//   seg_out       pattern to classifier, bit0 = segment a ... bit6 = segment g
//   busy          high from the cycle after start until the end of FINISH
//   done          one-cycle pulse in FINISH
//   mismatch      one-cycle pulse in SAMPLE when pred_in != expected digit
//   match_cnt     correct predictions in the current or last run
//   trial_cnt     completed trials
//   last_pred     pred_in captured at the most recent SAMPLE
// -----------------------------------------------------------------------------
module seg_pattern_driver #(
  parameter int unsigned LAT   = 1,
  parameter int unsigned CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [3:0]       digit_in,
  input  logic             noise_en,
  input  logic [CNT_W-1:0] num_trials,
  input  logic [3:0]       pred_in,
  output logic [6:0]       seg_out,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] trial_cnt,
  output logic [3:0]       last_pred
);

  // Wide enough to hold LAT+1 so the compare against LAT is exact for LAT = 0.
  localparam int unsigned        WAIT_W  = $clog2(LAT + 2);
  localparam logic [WAIT_W-1:0]  LAT_W   = WAIT_W'(LAT);
  localparam logic [WAIT_W-1:0]  WAIT_1  = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    APPLY  = 3'd1,
    SETTLE = 3'd2,
    SAMPLE = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q;
  logic              noise_q;
  logic [3:0]        digit_q;
  logic [CNT_W-1:0]  ntrials_q;
  logic [15:0]       lfsr_q;
  logic [WAIT_W-1:0] wait_q;
  logic [6:0]        seg_q;
  logic              busy_q;
  logic [CNT_W-1:0]  match_q;
  logic [CNT_W-1:0]  trial_q;
  logic [3:0]        last_pred_q;
  logic              last_trial_s;
  logic              pred_ok_s;
  logic              done_s;
  logic              mismatch_s;

  // 7-segment encoding; digits without a glyph produce a blank pattern.
  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Galois right-shift LFSR step, taps 16'hB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic [15:0] n;
    if (l[0]) begin
      n = (l >> 1) ^ 16'hB400;
    end else begin
      n = l >> 1;
    end
    return n;
  endfunction

  // Index 7 has no segment, so that LFSR value means "no flip this trial".
  function automatic logic [6:0] noise_mask(input logic en, input logic [15:0] l);
    logic [6:0] m;
    if (en && (l[2:0] != 3'd7)) begin
      m = 7'd1 << l[2:0];
    end else begin
      m = 7'd0;
    end
    return m;
  endfunction

  // Sweep successor: 9 and any out-of-range digit wrap to 0.
  function automatic logic [3:0] digit_next(input logic [3:0] d);
    logic [3:0] n;
    if (d >= 4'd9) begin
      n = 4'd0;
    end else begin
      n = d + 4'd1;
    end
    return n;
  endfunction

  assign last_trial_s = ((trial_q + CNT_ONE) == ntrials_q);
  assign pred_ok_s    = (pred_in == digit_q);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (num_trials == {CNT_W{1'b0}}) ? FINISH : APPLY;
        end else begin
          state_d = IDLE;
        end
      end
      APPLY: begin
        state_d = abort ? FINISH : SETTLE;
      end
      SETTLE: begin
        if (abort) begin
          state_d = FINISH;
        end else if (wait_q == LAT_W) begin
          state_d = SAMPLE;
        end else begin
          state_d = SETTLE;
        end
      end
      SAMPLE: begin
        // An abort here still lets the sampled trial count.
        state_d = (last_trial_s || abort) ? FINISH : APPLY;
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode for the single-cycle pulses.
  always_comb begin
    done_s     = 1'b0;
    mismatch_s = 1'b0;
    if (state_q == FINISH) begin
      done_s = 1'b1;
    end else if (state_q == SAMPLE) begin
      mismatch_s = !pred_ok_s;
    end else begin
      done_s     = 1'b0;
      mismatch_s = 1'b0;
    end
  end

  // Run configuration, LFSR, settle timer, pattern and scoreboard counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q      <= 1'b0;
      noise_q     <= 1'b0;
      digit_q     <= 4'd0;
      ntrials_q   <= {CNT_W{1'b0}};
      lfsr_q      <= SEED;
      wait_q      <= {WAIT_W{1'b0}};
      seg_q       <= 7'h00;
      busy_q      <= 1'b0;
      match_q     <= {CNT_W{1'b0}};
      trial_q     <= {CNT_W{1'b0}};
      last_pred_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mode_q    <= mode;
            noise_q   <= noise_en;
            digit_q   <= digit_in;
            ntrials_q <= num_trials;
            lfsr_q    <= SEED;
            match_q   <= {CNT_W{1'b0}};
            trial_q   <= {CNT_W{1'b0}};
            busy_q    <= 1'b1;
          end
        end
        APPLY: begin
          // An aborted trial leaves the pattern and LFSR untouched.
          if (!abort) begin
            seg_q  <= seg_enc(digit_q) ^ noise_mask(noise_q, lfsr_q);
            lfsr_q <= lfsr_step(lfsr_q);
            wait_q <= {WAIT_W{1'b0}};
          end
        end
        SETTLE: begin
          wait_q <= wait_q + WAIT_1;
        end
        SAMPLE: begin
          last_pred_q <= pred_in;
          trial_q     <= trial_q + CNT_ONE;
          if (pred_ok_s) begin
            match_q <= match_q + CNT_ONE;
          end
          if (mode_q) begin
            digit_q <= digit_next(digit_q);
          end
        end
        FINISH: begin
          busy_q <= 1'b0;
        end
        default: begin
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign seg_out   = seg_q;
  assign busy      = busy_q;
  assign done      = done_s;
  assign mismatch  = mismatch_s;
  assign match_cnt = match_q;
  assign trial_cnt = trial_q;
  assign last_pred = last_pred_q;

endmodule

// File: tb/tb_seg_pattern_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_pattern_driver
//
// Table-driven bench for seg_pattern_driver (LAT = 1, CNT_W = 8, SEED = ACE1).
// A small classifier responder registers a decode of seg_out (unknown
// patterns decode to 15), or can be forced to a stuck prediction of 3.
// Each table row describes one run and its hand-computed results; a reset
// during a run is exercised as a separate hand-written sequence.
// -----------------------------------------------------------------------------
module tb_seg_pattern_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic [3:0] digit_in;
  logic       noise_en;
  logic [7:0] num_trials;
  logic [3:0] pred_in;
  logic [6:0] seg_out;
  logic       busy;
  logic       done;
  logic       mismatch;
  logic [7:0] match_cnt;
  logic [7:0] trial_cnt;
  logic [3:0] last_pred;

  logic       stuck;
  logic [3:0] pred_r;

  int checks = 0;
  int errors = 0;

  seg_pattern_driver #(.LAT(1), .CNT_W(8), .SEED(16'hACE1)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .mode       (mode),
    .digit_in   (digit_in),
    .noise_en   (noise_en),
    .num_trials (num_trials),
    .pred_in    (pred_in),
    .seg_out    (seg_out),
    .busy       (busy),
    .done       (done),
    .mismatch   (mismatch),
    .match_cnt  (match_cnt),
    .trial_cnt  (trial_cnt),
    .last_pred  (last_pred)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'h3F; 4'd1: s = 7'h06; 4'd2: s = 7'h5B; 4'd3: s = 7'h4F;
      4'd4: s = 7'h66; 4'd5: s = 7'h6D; 4'd6: s = 7'h7D; 4'd7: s = 7'h07;
      4'd8: s = 7'h7F; 4'd9: s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] dec(input logic [6:0] s);
    logic [3:0] d;
    case (s)
      7'h3F: d = 4'd0; 7'h06: d = 4'd1; 7'h5B: d = 4'd2; 7'h4F: d = 4'd3;
      7'h66: d = 4'd4; 7'h6D: d = 4'd5; 7'h7D: d = 4'd6; 7'h07: d = 4'd7;
      7'h7F: d = 4'd8; 7'h6F: d = 4'd9;
      default: d = 4'd15;
    endcase
    return d;
  endfunction

  // Classifier stand-in with one cycle of latency.
  always @(posedge clk) pred_r <= dec(seg_out);
  assign pred_in = stuck ? 4'd3 : pred_r;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic       mode;
    logic [3:0] digit;
    logic       noise;
    logic [7:0] ntr;
    logic       stuck;
    int         abort_n;      // negedge index at which abort is raised (0 = none)
    int         busy_start_n; // negedge index at which a stray start is pulsed (0 = none)
    logic [6:0] exp_seg;
    logic [7:0] exp_match;
    logic [7:0] exp_trial;
    int         exp_mism;
    logic [3:0] exp_last;
    int         exp_done;     // edge count after the start edge at which done is seen
  } vec_t;

  vec_t vecs [7];

  task automatic run(input vec_t v, input int idx);
    logic [15:0] m_lfsr;
    logic [3:0]  m_dig;
    logic [6:0]  m_mask;
    int          n;
    int          k;
    int          mism;
    int          done_at;
    m_lfsr   = 16'hACE1;
    m_dig    = v.digit;
    mism     = 0;
    done_at  = -1;
    stuck    = v.stuck;
    mode     = v.mode;
    digit_in = v.digit;
    noise_en = v.noise;
    num_trials = v.ntr;
    start    = 1'b1;
    @(posedge clk);
    n = 0;
    forever begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (v.abort_n != 0 && n == v.abort_n) abort = 1'b1;
      if (v.abort_n != 0 && n == v.abort_n + 1) abort = 1'b0;
      if (v.busy_start_n != 0 && n == v.busy_start_n) begin
        start = 1'b1; digit_in = 4'd3; mode = 1'b1; num_trials = 8'd0;
      end
      if (v.busy_start_n != 0 && n == v.busy_start_n + 1) start = 1'b0;
      if (n >= 1 && ((n - 1) % 4) == 0) begin
        k = (n - 1) / 4;
        if (k < int'(v.ntr)) begin
          m_mask = (v.noise && m_lfsr[2:0] != 3'd7) ? (7'd1 << m_lfsr[2:0]) : 7'd0;
          chk($sformatf("run%0d seg trial%0d", idx, k + 1), int'(seg_out), int'(enc(m_dig) ^ m_mask));
          m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
          chk($sformatf("run%0d lfsr trial%0d", idx, k + 1), int'(dut.lfsr_q), int'(m_lfsr));
          if (v.mode) m_dig = (m_dig >= 4'd9) ? 4'd0 : m_dig + 4'd1;
        end
      end
      if (mismatch) mism++;
      if (done) begin
        done_at = n + 1;
        break;
      end
      if (n > 400) break;
      @(posedge clk);
      n++;
    end
    abort = 1'b0;
    chk($sformatf("run%0d done_cycle", idx), done_at, v.exp_done);
    chk($sformatf("run%0d busy_in_finish", idx), int'(busy), 1);
    chk($sformatf("run%0d match_cnt", idx), int'(match_cnt), int'(v.exp_match));
    chk($sformatf("run%0d trial_cnt", idx), int'(trial_cnt), int'(v.exp_trial));
    chk($sformatf("run%0d mismatches", idx), mism, v.exp_mism);
    chk($sformatf("run%0d last_pred", idx), int'(last_pred), int'(v.exp_last));
    chk($sformatf("run%0d seg_final", idx), int'(seg_out), int'(v.exp_seg));
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("run%0d done_pulse", idx), int'(done), 0);
    chk($sformatf("run%0d busy_after", idx), int'(busy), 0);
    chk($sformatf("run%0d seg_idle_hold", idx), int'(seg_out), int'(v.exp_seg));
  endtask

  initial begin
    // mode digit noise ntr stuck abort_n busy_start_n | seg match trial mism last done
    vecs[0] = '{1'b0, 4'd8,  1'b0, 8'd4,  1'b0, 0, 6, 7'h7F, 8'd4,  8'd4,  0, 4'd8,  17};
    vecs[1] = '{1'b1, 4'd0,  1'b0, 8'd12, 1'b0, 0, 0, 7'h06, 8'd12, 8'd12, 0, 4'd1,  49};
    vecs[2] = '{1'b0, 4'd5,  1'b0, 8'd0,  1'b0, 0, 0, 7'h06, 8'd0,  8'd0,  0, 4'd1,  1};
    vecs[3] = '{1'b1, 4'd0,  1'b0, 8'd10, 1'b1, 0, 0, 7'h6F, 8'd1,  8'd10, 9, 4'd3,  41};
    vecs[4] = '{1'b0, 4'd0,  1'b1, 8'd2,  1'b0, 0, 0, 7'h3E, 8'd0,  8'd2,  2, 4'd15, 9};
    vecs[5] = '{1'b1, 4'd12, 1'b0, 8'd3,  1'b0, 0, 0, 7'h06, 8'd2,  8'd3,  1, 4'd1,  13};
    vecs[6] = '{1'b0, 4'd8,  1'b0, 8'd5,  1'b0, 9, 0, 7'h7F, 8'd2,  8'd2,  0, 4'd8,  11};

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 1'b0; digit_in = 4'd0;
    noise_en = 1'b0; num_trials = 8'd0; stuck = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset seg_out", int'(seg_out), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset lfsr", int'(dut.lfsr_q), 16'hACE1);
    rst = 1'b0;
    // abort alone in IDLE must not start anything
    abort = 1'b1;
    repeat (2) @(negedge clk);
    abort = 1'b0;
    chk("idle abort busy", int'(busy), 0);
    chk("idle abort done", int'(done), 0);

    for (int i = 0; i < 7; i++) begin
      run(vecs[i], i);
    end

    // Reset asserted in SETTLE of trial 2 of a sweep run.
    stuck = 1'b0; mode = 1'b1; digit_in = 4'd0; noise_en = 1'b1; num_trials = 8'd4;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset trial_cnt", int'(trial_cnt), 1);
    chk("pre-reset busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    chk("midrun rst seg_out", int'(seg_out), 0);
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst done", int'(done), 0);
    chk("midrun rst mismatch", int'(mismatch), 0);
    chk("midrun rst match_cnt", int'(match_cnt), 0);
    chk("midrun rst trial_cnt", int'(trial_cnt), 0);
    chk("midrun rst last_pred", int'(last_pred), 0);
    chk("midrun rst lfsr", int'(dut.lfsr_q), 16'hACE1);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("post-rst idle busy", int'(busy), 0);
    chk("post-rst idle seg", int'(seg_out), 0);
    chk("post-rst idle trial", int'(trial_cnt), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_pattern_driver.md
Name: seg_pattern_driver

Overview:
- Stimulus source and scoreboard for the 7-input digit classifier.
- Encodes a digit (0-9) into the 7-segment pattern the classifier consumes on ui_in[6:0], optionally flips one segment using an LFSR, and waits for the registered prediction on uo_out[3:0].
- Compares each prediction against the clean digit and keeps match and trial counters for on-chip accuracy runs.

Parameters:
- LAT, 1: classifier latency in clock cycles from pattern change to valid prediction.
- CNT_W, 8: width of the trial and match counters and of num_trials.
- SEED, 16'hACE1: LFSR seed, loaded on reset and on every accepted start.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins a run when sampled high in IDLE; ignored otherwise
- abort  in  1  ends the current run early; ignored in IDLE
- mode  in  1  0 = fixed digit taken from digit_in, 1 = sweep starting at digit_in
- digit_in  in  4  start/fixed digit, latched at start
- noise_en  in  1  enables single-segment flip, latched at start
- num_trials  in  CNT_W  trials per run, latched at start
- pred_in  in  4  classifier prediction (uo_out[3:0])
- seg_out  out  7  pattern to classifier; bit0 = segment a … bit6 = segment g
- busy  out  1  high from the cycle after start until FINISH
- done  out  1  one-cycle pulse in FINISH
- mismatch  out  1  one-cycle pulse in SAMPLE when pred_in != expected
- match_cnt  out  CNT_W  correct predictions in the current or last run
- trial_cnt  out  CNT_W  completed trials
- last_pred  out  4  pred_in captured at the most recent SAMPLE

Behaviour:
- Reset values: seg_out = 0, busy = 0, done = 0, mismatch = 0, match_cnt = 0, trial_cnt = 0, last_pred = 0, lfsr = SEED, state = IDLE. Reset mid-run drops everything to these values immediately.
- Segment encoding:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F (hex).
  - Digits 10-15 encode to 00, and expected = the digit value.
- LFSR: 16-bit Galois, right shift. If bit0 = 1, next = (lfsr >> 1) ^ 16'hB400; otherwise next = lfsr >> 1. It advances once per APPLY.
- Noise mask: computed from the pre-advance LFSR value.
  - If noise_en and lfsr[2:0] != 7, mask = 1 << lfsr[2:0].
  - Otherwise mask = 0.
  - expected is always the clean digit.
- FSM:
  - IDLE, start = 1:
    - Latch mode, digit_in, noise_en and num_trials.
    - Clear match_cnt and trial_cnt, and set lfsr = SEED.
    - Set busy = 1.
    - Go to APPLY, or to FINISH if num_trials == 0.
  - APPLY (1 cycle): seg_out <= enc(cur_digit) ^ mask; lfsr advances; wait_cnt <= 0; go to SETTLE.
  - SETTLE: wait_cnt increments each cycle; go to SAMPLE when wait_cnt == LAT. SETTLE lasts LAT+1 cycles.
  - SAMPLE (1 cycle):
    - last_pred <= pred_in.
    - If pred_in == expected, match_cnt++; otherwise pulse mismatch.
    - trial_cnt++.
    - In sweep mode cur_digit++, wrapping 9 -> 0; a start digit above 9 wraps to 0 on its first increment.
    - Go to FINISH if trial_cnt+1 == num_trials, otherwise go to APPLY.
  - FINISH (1 cycle): done = 1, busy <= 0, go to IDLE.
- Trial period is LAT+3 cycles.
- seg_out holds its last value in IDLE and FINISH.
- abort:
  - Sampled in APPLY or SETTLE: next state is FINISH, and no count update for the interrupted trial.
  - Sampled in SAMPLE: that trial completes, then FINISH.
- Counters cannot overflow, because trial_cnt <= num_trials <= 2^CNT_W - 1.
- When start and abort are high together in IDLE, start wins and abort is ignored.

Test Plan:
- Reset: assert rst in SETTLE of trial 2 -> all outputs 0 in the same cycle; lfsr = ACE1; state IDLE. After release, idle until start.
- Fixed, clean: mode = 0, digit_in = 8, noise_en = 0, num_trials = 4, responder echoes the correct digit with LAT = 1.
  - seg_out = 7F.
  - done pulses 17 cycles after start is sampled (1 + 4×4).
  - match_cnt = 4, trial_cnt = 4, no mismatch pulses.
- Sweep wrap: mode = 1, digit_in = 0, num_trials = 12, ideal responder -> seg_out sequence 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F, 3F, 06; match_cnt = 12.
- Stuck classifier: pred_in fixed at 3, mode = 1, digit_in = 0, num_trials = 10 -> match_cnt = 1, 9 mismatch pulses, last_pred = 3.
- Noise: mode = 0, digit_in = 0, noise_en = 1, num_trials = 2, SEED = ACE1.
  - Trial 1: seg_out = 3D (flip index 1); lfsr becomes E270.
  - Trial 2: seg_out = 3E (flip index 0).
- Edge cases:
  - num_trials = 0 -> done one cycle after IDLE exit, seg_out unchanged, counters 0.
  - start pulsed while busy -> ignored.
  - abort in SETTLE of trial 3 -> FINISH next cycle, trial_cnt = 2.
